// File: rtl/cond_exec_controller.sv
// Purpose: ARM-style conditional-execution controller: flag register, condition evaluation, flag-hazard stall, branch flush, statistics.
// Latency: decisions are combinational in the ID cycle; flags written by EX are visible to ID one cycle later.
// Backpressure: stall holds PC and IF/ID for exactly one cycle on a flag hazard; flush drops the ID slot for one cycle after a taken branch.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid, id_cond, id_is_branch   instruction in ID: valid, condition field, branch flag
//   ex_valid, ex_set_flags, ex_flags  instruction in EX: valid, S bit, ALU flags {N,Z,C,V}
//   cnt_clr                       synchronous clear of the statistics counters
//   status_register               current {N,Z,C,V}
//   stall, flush                  pipeline control
//   id_exec, id_kill, branch_taken    ID decision
//   exec_count, kill_count        saturating statistics counters
module cond_exec_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_is_branch,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic [3:0]       ex_flags,
    input  logic             cnt_clr,
    output logic [3:0]       status_register,
    output logic             stall,
    output logic             flush,
    output logic             id_exec,
    output logic             id_kill,
    output logic             branch_taken,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] kill_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] COND_AL = 4'b1110;

    state_t state;
    logic   pass;
    logic   hazard;
    logic   flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = status_register;

    always_comb begin
        pass = 1'b0;
        case (id_cond)
            4'b0000: pass = flag_z;
            4'b0001: pass = ~flag_z;
            4'b0010: pass = flag_c;
            4'b0011: pass = ~flag_c;
            4'b0100: pass = flag_n;
            4'b0101: pass = ~flag_n;
            4'b0110: pass = flag_v;
            4'b0111: pass = ~flag_v;
            4'b1000: pass = flag_c & ~flag_z;
            4'b1001: pass = ~flag_c | flag_z;
            4'b1010: pass = (flag_n == flag_v);
            4'b1011: pass = (flag_n != flag_v);
            4'b1100: pass = ~flag_z & (flag_n == flag_v);
            4'b1101: pass = flag_z | (flag_n != flag_v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Only RUN can raise a hazard: in STALL the producing instruction has
    // already written the flags, so ID may evaluate against them directly.
    assign hazard = (state == S_RUN) & id_valid & (id_cond != COND_AL)
                  & ex_valid & ex_set_flags;

    // Outputs are gated by rst so a reset asserted mid-cycle drops
    // stall/flush immediately rather than at the next edge.
    always_comb begin
        stall        = 1'b0;
        flush        = 1'b0;
        id_exec      = 1'b0;
        id_kill      = 1'b0;
        branch_taken = 1'b0;
        if (!rst) begin
            if (state == S_FLUSH) begin
                flush = 1'b1;
            end else begin
                stall        = hazard;
                id_exec      = id_valid & ~hazard & pass;
                id_kill      = id_valid & ~hazard & ~pass;
                branch_taken = id_valid & ~hazard & pass & id_is_branch;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (hazard)            state <= S_STALL;
                    else if (branch_taken) state <= S_FLUSH;
                    else                   state <= S_RUN;
                end
                S_STALL: begin
                    if (branch_taken) state <= S_FLUSH;
                    else              state <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_register <= 4'b0000;
        end else if (ex_valid && ex_set_flags) begin
            status_register <= ex_flags;
        end
    end

    // Counters saturate at all-ones; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_count <= '0;
            kill_count <= '0;
        end else if (cnt_clr) begin
            exec_count <= '0;
            kill_count <= '0;
        end else begin
            if (id_exec && (exec_count != {CNT_W{1'b1}}))
                exec_count <= exec_count + CNT_W'(1);
            if (id_kill && (kill_count != {CNT_W{1'b1}}))
                kill_count <= kill_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cond_exec_controller.sv
module tb_cond_exec_controller;

    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid = 1'b0;
    logic [3:0]    id_cond = 4'd0;
    logic          id_is_branch = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_set_flags = 1'b0;
    logic [3:0]    ex_flags = 4'd0;
    logic          cnt_clr = 1'b0;
    logic [3:0]    status_register;
    logic          stall, flush, id_exec, id_kill, branch_taken;
    logic [CW-1:0] exec_count, kill_count;

    int n_checks = 0;
    int n_errors = 0;

    cond_exec_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_cond(id_cond), .id_is_branch(id_is_branch),
        .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_flags(ex_flags),
        .cnt_clr(cnt_clr),
        .status_register(status_register),
        .stall(stall), .flush(flush), .id_exec(id_exec), .id_kill(id_kill),
        .branch_taken(branch_taken),
        .exec_count(exec_count), .kill_count(kill_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 = normal issue, 1 = second look after a flag-hazard stall,
    //       2 = slot being discarded after a taken branch
    logic [3:0] m_status;
    int         m_mode;
    int         m_exec_cnt, m_kill_cnt;
    logic       m_stall, m_flush, m_exec, m_kill, m_br;

    // Conditions come in complementary pairs: even code tests a predicate,
    // the following odd code its negation (AL/NV included).
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] s);
        logic n, z, cy, v, base;
        {n, z, cy, v} = s;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic model_eval();
        logic p, hz;
        p = cond_pass(id_cond, m_status);
        m_stall = 0; m_flush = 0; m_exec = 0; m_kill = 0; m_br = 0;
        if (m_mode == 2) begin
            m_flush = 1;
        end else begin
            hz = (m_mode == 0) && id_valid && (id_cond != 4'd14) && ex_valid && ex_set_flags;
            m_stall = hz;
            m_exec  = id_valid && !hz && p;
            m_kill  = id_valid && !hz && !p;
            m_br    = m_exec && id_is_branch;
        end
    endtask

    task automatic model_reset();
        m_status = 4'd0; m_mode = 0; m_exec_cnt = 0; m_kill_cnt = 0;
    endtask

    // Drive one cycle's inputs after the falling edge and evaluate the model.
    task automatic drive(input logic v, input logic [3:0] c, input logic br,
                         input logic exv, input logic sf, input logic [3:0] fl,
                         input logic clr);
        @(negedge clk);
        id_valid = v; id_cond = c; id_is_branch = br;
        ex_valid = exv; ex_set_flags = sf; ex_flags = fl; cnt_clr = clr;
        #1;
        model_eval();
    endtask

    // Advance through the rising edge and move the model to its next state.
    task automatic tick();
        @(posedge clk);
        if (m_mode == 2)   m_mode = 0;
        else if (m_stall)  m_mode = 1;
        else if (m_br)     m_mode = 2;
        else               m_mode = 0;
        if (ex_valid && ex_set_flags) m_status = ex_flags;
        if (cnt_clr) begin
            m_exec_cnt = 0; m_kill_cnt = 0;
        end else begin
            if (m_exec && m_exec_cnt < MAXC) m_exec_cnt++;
            if (m_kill && m_kill_cnt < MAXC) m_kill_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; id_valid = 0; id_cond = 0; id_is_branch = 0;
        ex_valid = 0; ex_set_flags = 0; ex_flags = 0; cnt_clr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        drive(1, 4'd0, 0, 1, 1, 4'b1111, 0);
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_pre_hazard: stall=%b want 1", stall); end
        #2 rst = 1; #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_drops_stall: stall=%b want 0", stall); end
        n_checks++; if ({id_exec, id_kill, branch_taken, flush} !== 4'b0000) begin n_errors++; $display("FAIL reset_outputs: got %b want 0000", {id_exec, id_kill, branch_taken, flush}); end
        @(posedge clk); #1;
        n_checks++; if (status_register !== 4'b0000) begin n_errors++; $display("FAIL reset_status: got %b want 0000", status_register); end
        n_checks++; if ({exec_count, kill_count} !== 8'h00) begin n_errors++; $display("FAIL reset_counts: got %h want 00", {exec_count, kill_count}); end
        do_reset();
    endtask

    task automatic test_kill_eq();
        do_reset();
        drive(1, 4'd0, 0, 0, 0, 4'd0, 0);
        n_checks++; if ({id_exec, id_kill} !== 2'b01) begin n_errors++; $display("FAIL eq_kill: exec/kill=%b want 01", {id_exec, id_kill}); end
        tick();
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0);
        n_checks++; if (kill_count !== 4'd1 || exec_count !== 4'd0) begin n_errors++; $display("FAIL eq_kill_count: kill=%0d exec=%0d want 1,0", kill_count, exec_count); end
        n_checks++; if ({id_exec, id_kill, branch_taken, stall} !== 4'b0000) begin n_errors++; $display("FAIL idle_outputs: got %b want 0000", {id_exec, id_kill, branch_taken, stall}); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 4'd0, 0, 1, 1, 4'b0100, 0);
        n_checks++; if ({stall, id_exec, id_kill} !== 3'b100) begin n_errors++; $display("FAIL stall_assert: stall/exec/kill=%b want 100", {stall, id_exec, id_kill}); end
        tick();
        drive(1, 4'd0, 0, 0, 0, 4'd0, 0);
        n_checks++; if (status_register !== 4'b0100) begin n_errors++; $display("FAIL stall_status: got %b want 0100", status_register); end
        n_checks++; if ({stall, id_exec} !== 2'b01) begin n_errors++; $display("FAIL stall_release: stall/exec=%b want 01", {stall, id_exec}); end
        tick();
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0);
        n_checks++; if (exec_count !== 4'd1) begin n_errors++; $display("FAIL stall_exec_count: got %0d want 1", exec_count); end
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 4'd14, 1, 0, 0, 4'd0, 0);
        n_checks++; if ({branch_taken, id_exec, flush} !== 3'b110) begin n_errors++; $display("FAIL branch_taken: br/exec/flush=%b want 110", {branch_taken, id_exec, flush}); end
        tick();
        drive(1, 4'd14, 1, 0, 0, 4'd0, 0);
        n_checks++; if ({flush, id_exec, id_kill, branch_taken, stall} !== 5'b10000) begin n_errors++; $display("FAIL branch_flush: got %b want 10000", {flush, id_exec, id_kill, branch_taken, stall}); end
        tick();
        drive(1, 4'd14, 0, 0, 0, 4'd0, 0);
        n_checks++; if ({flush, id_exec} !== 2'b01) begin n_errors++; $display("FAIL branch_resume: flush/exec=%b want 01", {flush, id_exec}); end
        tick();
    endtask

    task automatic test_cond_table();
        logic [3:0] conds [4]   = '{4'd9, 4'd10, 4'd13, 4'd15};
        logic [3:0] stats [4]   = '{4'b0010, 4'b1001, 4'b0100, 4'b0000};
        logic       want_ex [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 4'd0, 0, 1, 1, stats[i], 0);
            tick();
            drive(1, conds[i], 0, 0, 0, 4'd0, 0);
            n_checks++; if ({id_exec, id_kill} !== {want_ex[i], !want_ex[i]}) begin n_errors++; $display("FAIL cond_table[%0d]: exec/kill=%b want %b", i, {id_exec, id_kill}, {want_ex[i], !want_ex[i]}); end
            tick();
        end
        for (int s = 0; s < 16; s++) begin
            drive(0, 4'd0, 0, 1, 1, 4'(s), 0);
            tick();
            drive(1, 4'd15, 0, 0, 0, 4'd0, 0);
            n_checks++; if ({id_exec, id_kill} !== 2'b01) begin n_errors++; $display("FAIL cond_nv[%0d]: exec/kill=%b want 01", s, {id_exec, id_kill}); end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (17) begin
            drive(1, 4'd14, 0, 0, 0, 4'd0, 0);
            tick();
        end
        drive(1, 4'd14, 0, 0, 0, 4'd0, 1);
        n_checks++; if (exec_count !== 4'd15) begin n_errors++; $display("FAIL sat_exec: got %0d want 15", exec_count); end
        tick();
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0);
        n_checks++; if (exec_count !== 4'd0) begin n_errors++; $display("FAIL clr_priority: got %0d want 0", exec_count); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        drive(1, 4'd14, 1, 1, 1, 4'b1010, 0);
        tick();
        drive(1, 4'd14, 0, 0, 0, 4'd0, 0);
        n_checks++; if ({flush, status_register} !== 5'b11010) begin n_errors++; $display("FAIL flush_pre: flush/status=%b want 11010", {flush, status_register}); end
        #2 rst = 1; #1;
        n_checks++; if (flush !== 1'b0 || status_register !== 4'b0000) begin n_errors++; $display("FAIL rst_in_flush: flush=%b status=%b want 0 0000", flush, status_register); end
        @(negedge clk);
        rst = 0;
        model_reset();
        drive(1, 4'd14, 0, 0, 0, 4'd0, 0);
        n_checks++; if ({flush, id_exec} !== 2'b01) begin n_errors++; $display("FAIL rst_resume: flush/exec=%b want 01", {flush, id_exec}); end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] c;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom_range(0, 31) == 0);
            n_checks++; if ({stall, flush, id_exec, id_kill, branch_taken} !== {m_stall, m_flush, m_exec, m_kill, m_br}) begin n_errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, {stall, flush, id_exec, id_kill, branch_taken}, {m_stall, m_flush, m_exec, m_kill, m_br}); end
            n_checks++; if (status_register !== m_status) begin n_errors++; $display("FAIL rand_status[%0d]: got %b want %b", i, status_register, m_status); end
            n_checks++; if (int'(exec_count) != m_exec_cnt || int'(kill_count) != m_kill_cnt) begin n_errors++; $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", i, exec_count, kill_count, m_exec_cnt, m_kill_cnt); end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_kill_eq();
        test_stall();
        test_branch();
        test_cond_table();
        test_saturation();
        test_reset_in_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cond_exec_controller.md
COND_EXEC_CONTROLLER -- requirements
Module: cond_exec_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port id_valid, input, 1: ID stage holds a real instruction.
REQ-005 SHALL have port id_cond, input, 4: ID instruction condition field, standard ARM encoding (EQ=0000 ... LE=1101, AL=1110, NV=1111).
REQ-006 SHALL have port id_is_branch, input, 1: ID instruction is a branch.
REQ-007 SHALL have port ex_valid, input, 1: EX stage holds an executing (condition-passed) instruction.
REQ-008 SHALL have port ex_set_flags, input, 1: EX instruction has S bit set.
REQ-009 SHALL have port ex_flags, input, 4: ALU result flags {N,Z,C,V}.
REQ-010 SHALL have port cnt_clr, input, 1: synchronous clear of both counters.
REQ-011 SHALL have port status_register, output, 4: current {N,Z,C,V}.
REQ-012 SHALL have port stall, output, 1: hold PC and IF/ID; insert bubble into EX.
REQ-013 SHALL have port flush, output, 1: discard the instruction in ID this cycle.
REQ-014 SHALL have port id_exec, output, 1: ID instruction proceeds.
REQ-015 SHALL have port id_kill, output, 1: ID instruction converted to bubble (condition failed).
REQ-016 SHALL have port branch_taken, output, 1: redirect fetch to branch target.
REQ-017 SHALL have ports exec_count and kill_count, output, CNT_W each: statistics.

Function
REQ-018 pass SHALL be evaluated from id_cond and status_register: EQ z; NE ~z; CS c; CC ~c; MI n; PL ~n; VS v; VC ~v; HI c&~z; LS ~c|z; GE n==v; LT n!=v; GT ~z&(n==v); LE z|(n!=v); AL 1; NV 0.
REQ-019 status_register SHALL load ex_flags at the clock edge when ex_valid & ex_set_flags, in any state; otherwise it holds.
REQ-020 hazard SHALL be id_valid & (id_cond!=AL) & ex_valid & ex_set_flags.
REQ-021 The FSM SHALL have states RUN, STALL and FLUSH.
REQ-022 RUN: stall=hazard; id_exec=id_valid&~hazard&pass; id_kill=id_valid&~hazard&~pass; branch_taken=id_exec&id_is_branch; flush=0.
REQ-023 RUN next state: hazard -> STALL; else branch_taken -> FLUSH; else RUN.
REQ-024 STALL: outputs as RUN with hazard forced 0, using the status_register updated at entry; next state: branch_taken -> FLUSH, else RUN. Stall SHALL last exactly one cycle.
REQ-025 FLUSH: flush=1; stall, id_exec, id_kill and branch_taken = 0; next state RUN unconditionally.
REQ-026 Outputs SHALL be combinational from state, inputs and status_register, with no extra latency; status changes SHALL take effect one cycle after the producing EX cycle.
REQ-027 exec_count SHALL increment on id_exec and kill_count on id_kill, each saturating at 2^CNT_W-1 (no wrap).
REQ-028 cnt_clr SHALL zero both counters at the next edge, with priority over a same-cycle increment.
REQ-029 When id_valid=0, id_exec, id_kill and branch_taken SHALL be 0 and no hazard SHALL be raised.

Reset
REQ-030 rst=1 SHALL immediately force state RUN, status_register 0000, and both counters 0, independent of clk.
REQ-031 Reset asserted mid-STALL or mid-FLUSH SHALL drop stall/flush in the same cycle; operation resumes in RUN on the first edge after release.

Verification
REQ-032 After reset, id_valid=1, id_cond=EQ, status 0000 -> id_kill=1, id_exec=0; next cycle kill_count=1.
REQ-033 id_cond=EQ with ex_valid=1, ex_set_flags=1, ex_flags=0100 -> stall=1 for one cycle; next cycle status_register=0100, stall=0, id_exec=1.
REQ-034 id_cond=AL, id_is_branch=1 -> branch_taken=1 the same cycle; next cycle flush=1 and id_exec=0; following cycle RUN.
REQ-035 Condition table: LS with status 0010 -> kill; GE with 1001 -> exec; LE with 0100 -> exec; NV -> kill under every status value.
REQ-036 CNT_W=4, 17 consecutive id_exec -> exec_count=15; cnt_clr asserted with id_exec=1 -> 0.
REQ-037 rst asserted during FLUSH -> flush=0 and status_register=0000 before the next edge.
